// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage between the warp scheduler and decode.
// Issues word-aligned I-cache reads tagged by warp id. It keeps per-warp
// metadata for the in-flight fetch and re-joins each response with that
// metadata. Results go out through a 2-entry elastic output buffer.
module fetch_stage #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [NW_WIDTH-1:0]    sched_wid,
    input  logic [NUM_THREADS-1:0] sched_tmask,
    input  logic [XLEN-1:0]        sched_pc,
    input  logic [UUID_WIDTH-1:0]  sched_uuid,

    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [XLEN-3:0]        icache_req_addr,
    output logic [NW_WIDTH-1:0]    icache_req_tag,

    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [31:0]            icache_rsp_data,
    input  logic [NW_WIDTH-1:0]    icache_rsp_tag,

    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [NW_WIDTH-1:0]    fetch_wid,
    output logic [NUM_THREADS-1:0] fetch_tmask,
    output logic [XLEN-1:0]        fetch_pc,
    output logic [UUID_WIDTH-1:0]  fetch_uuid,
    output logic [31:0]            fetch_instr,

    output logic [NUM_WARPS-1:0]   pending_warps,
    output logic                   tag_error,
    output logic [31:0]            perf_icache_stalls
);

    // Metadata remembered for the single outstanding fetch of a warp.
    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic [UUID_WIDTH-1:0]  uuid;
    } meta_t;

    // One fetched-instruction bundle as held in the output buffer.
    typedef struct packed {
        logic [NW_WIDTH-1:0] wid;
        meta_t               meta;
        logic [31:0]         instr;
    } entry_t;

    logic [NUM_WARPS-1:0] pending_q;
    meta_t                table_q [NUM_WARPS];
    entry_t               fifo_q  [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 tag_error_q;
    logic [31:0]          stalls_q;

    logic   req_blocked;
    logic   req_fire;
    logic   rsp_fire;
    logic   rsp_hit;
    logic   push;
    logic   pop;
    logic   stall;
    entry_t push_entry;
    entry_t head;

    // The low PC bits are architecturally zero and are not forwarded.
    logic unused_pc_bits;
    assign unused_pc_bits = ^sched_pc[1:0];

    // Handshake decode. Gating uses the registered pending bits, so a warp whose
    // response fires this cycle is still blocked until the next cycle.
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        req_blocked      = 1'b0;
        icache_req_valid = 1'b0;
        sched_ready      = 1'b0;
        req_fire         = 1'b0;
        rsp_hit          = 1'b0;
        rsp_fire         = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
        stall            = 1'b0;

        req_blocked      = pending_q[sched_wid];
        icache_req_valid = sched_valid && !req_blocked;
        sched_ready      = icache_req_ready && !req_blocked;
        req_fire         = sched_valid && sched_ready;
        stall            = icache_req_valid && !icache_req_ready;

        rsp_hit          = pending_q[icache_rsp_tag];
        rsp_fire         = icache_rsp_valid && icache_rsp_ready;
        push             = rsp_fire && rsp_hit;
        pop              = fetch_valid && fetch_ready;
    end

    assign icache_req_addr  = sched_pc[XLEN-1:2];
    assign icache_req_tag   = sched_wid;
    assign icache_rsp_ready = (count_q != 2'd2);

    assign push_entry = '{wid: icache_rsp_tag, meta: table_q[icache_rsp_tag], instr: icache_rsp_data};

    // Pending bits: set on request fire, cleared when the matching response is accepted.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            if (push) begin
                pending_q[icache_rsp_tag] <= 1'b0;
            end
            if (req_fire) begin
                pending_q[sched_wid] <= 1'b1;
            end
        end
    end

    // Capture the metadata of each issued fetch.
    // NOTE: the table has no reset; an entry is read only while its pending bit is set.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            table_q[sched_wid] <= '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
        end
    end

    // Two-entry output buffer. Push and pop may coincide at any occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag for a response whose warp had no outstanding fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_error_q <= 1'b0;
        end else if (rsp_fire && !rsp_hit) begin
            tag_error_q <= 1'b1;
        end
    end

    // Count the cycles in which a request is offered but the cache refuses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stalls_q <= '0;
        end else if (stall) begin
            stalls_q <= stalls_q + 32'd1;
        end
    end

    assign head               = fifo_q[rd_ptr_q];
    assign fetch_valid        = (count_q != 2'd0);
    assign fetch_wid          = head.wid;
    assign fetch_tmask        = head.meta.tmask;
    assign fetch_pc           = head.meta.pc;
    assign fetch_uuid         = head.meta.uuid;
    assign fetch_instr        = head.instr;
    assign pending_warps      = pending_q;
    assign tag_error          = tag_error_q;
    assign perf_icache_stalls = stalls_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. It runs directed scenarios and then randomized
// traffic. Expected values come from a queue/array reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_valid;
    logic        sched_ready;
    logic [1:0]  sched_wid;
    logic [3:0]  sched_tmask;
    logic [31:0] sched_pc;
    logic [43:0] sched_uuid;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [29:0] icache_req_addr;
    logic [1:0]  icache_req_tag;
    logic        icache_rsp_valid;
    logic        icache_rsp_ready;
    logic [31:0] icache_rsp_data;
    logic [1:0]  icache_rsp_tag;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_wid;
    logic [3:0]  fetch_tmask;
    logic [31:0] fetch_pc;
    logic [43:0] fetch_uuid;
    logic [31:0] fetch_instr;
    logic [3:0]  pending_warps;
    logic        tag_error;
    logic [31:0] perf_icache_stalls;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .sched_valid        (sched_valid),
        .sched_ready        (sched_ready),
        .sched_wid          (sched_wid),
        .sched_tmask        (sched_tmask),
        .sched_pc           (sched_pc),
        .sched_uuid         (sched_uuid),
        .icache_req_valid   (icache_req_valid),
        .icache_req_ready   (icache_req_ready),
        .icache_req_addr    (icache_req_addr),
        .icache_req_tag     (icache_req_tag),
        .icache_rsp_valid   (icache_rsp_valid),
        .icache_rsp_ready   (icache_rsp_ready),
        .icache_rsp_data    (icache_rsp_data),
        .icache_rsp_tag     (icache_rsp_tag),
        .fetch_valid        (fetch_valid),
        .fetch_ready        (fetch_ready),
        .fetch_wid          (fetch_wid),
        .fetch_tmask        (fetch_tmask),
        .fetch_pc           (fetch_pc),
        .fetch_uuid         (fetch_uuid),
        .fetch_instr        (fetch_instr),
        .pending_warps      (pending_warps),
        .tag_error          (tag_error),
        .perf_icache_stalls (perf_icache_stalls)
    );

    typedef struct {
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [43:0] uuid;
    } meta_t;

    typedef struct {
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [43:0] uuid;
        logic [31:0] instr;
    } exp_t;

    // Reference model: outstanding warps, their metadata, and the expected output sequence.
    bit          m_pend [4];
    meta_t       m_tbl  [4];
    exp_t        m_q    [$];
    logic        m_terr;
    logic [31:0] m_stalls;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_q.delete();
        m_terr   = 1'b0;
        m_stalls = '0;
    endtask

    task automatic compare_all();
        logic [3:0] pv;
        for (int i = 0; i < 4; i++) pv[i] = m_pend[i];
        chk("sched_ready", sched_ready, icache_req_ready && !m_pend[sched_wid]);
        chk("req_valid", icache_req_valid, sched_valid && !m_pend[sched_wid]);
        chk("req_addr", icache_req_addr, sched_pc / 4);
        chk("req_tag", icache_req_tag, sched_wid);
        chk("rsp_ready", icache_rsp_ready, m_q.size() < 2);
        chk("fetch_valid", fetch_valid, m_q.size() != 0);
        chk("pending", pending_warps, pv);
        chk("tag_error", tag_error, m_terr);
        chk("stalls", perf_icache_stalls, m_stalls);
        if (m_q.size() != 0) begin
            chk("fetch_wid", fetch_wid, m_q[0].wid);
            chk("fetch_tmask", fetch_tmask, m_q[0].tmask);
            chk("fetch_pc", fetch_pc, m_q[0].pc);
            chk("fetch_uuid", fetch_uuid, m_q[0].uuid);
            chk("fetch_instr", fetch_instr, m_q[0].instr);
        end
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic cycle();
        bit   rf, sf, hit, pop, stall;
        exp_t e;
        #1;
        if (chk_en) compare_all();
        rf    = sched_valid && icache_req_ready && !m_pend[sched_wid];
        stall = sched_valid && !m_pend[sched_wid] && !icache_req_ready;
        sf    = icache_rsp_valid && (m_q.size() < 2);
        hit   = m_pend[icache_rsp_tag];
        pop   = (m_q.size() != 0) && fetch_ready;
        e.wid   = icache_rsp_tag;
        e.tmask = m_tbl[icache_rsp_tag].tmask;
        e.pc    = m_tbl[icache_rsp_tag].pc;
        e.uuid  = m_tbl[icache_rsp_tag].uuid;
        e.instr = icache_rsp_data;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (pop) m_q.delete(0);
            if (sf) begin
                if (hit) begin
                    m_q.push_back(e);
                    m_pend[icache_rsp_tag] = 1'b0;
                end else begin
                    m_terr = 1'b1;
                end
            end
            if (rf) begin
                m_tbl[sched_wid] = '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
                m_pend[sched_wid] = 1'b1;
            end
            if (stall) m_stalls = m_stalls + 32'd1;
        end
        #1;
    endtask

    task automatic sched(input logic [1:0] w, input logic [31:0] pc, input logic [3:0] tm, input logic [43:0] uu);
        sched_valid = 1'b1;
        sched_wid   = w;
        sched_pc    = pc;
        sched_tmask = tm;
        sched_uuid  = uu;
    endtask

    task automatic rsp(input logic [1:0] t, input logic [31:0] d);
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = t;
        icache_rsp_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        sched_valid = 1'b0; sched_wid = '0; sched_tmask = '0; sched_pc = '0; sched_uuid = '0;
        icache_req_ready = 1'b1;
        icache_rsp_valid = 1'b0; icache_rsp_data = '0; icache_rsp_tag = '0;
        fetch_ready = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) m_tbl[i] = '{tmask: '0, pc: '0, uuid: '0};

        // Reset state
        cycle();
        cycle();
        reset  = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_pending", pending_warps, 4'b0000);
        chk("rst_tag_error", tag_error, 1'b0);
        chk("rst_stalls", perf_icache_stalls, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_fetch_uuid", fetch_uuid, 44'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_sched_ready", sched_ready, 1'b1);

        // Single fetch
        sched(2'd1, 32'h8000_0010, 4'b0011, 44'd5);
        #1;
        chk("single_addr", icache_req_addr, 30'h2000_0004);
        chk("single_tag", icache_req_tag, 2'd1);
        cycle();
        sched_valid = 1'b0;
        chk("single_pending", pending_warps, 4'b0010);
        rsp(2'd1, 32'hDEAD_BEEF);
        cycle();
        icache_rsp_valid = 1'b0;
        chk("single_valid", fetch_valid, 1'b1);
        chk("single_wid", fetch_wid, 2'd1);
        chk("single_pc", fetch_pc, 32'h8000_0010);
        chk("single_tmask", fetch_tmask, 4'b0011);
        chk("single_uuid", fetch_uuid, 44'd5);
        chk("single_instr", fetch_instr, 32'hDEAD_BEEF);
        chk("single_pend_clr", pending_warps, 4'b0000);
        cycle();

        // Per-warp blocking, including the cycle in which the response fires
        sched(2'd2, 32'h0000_0100, 4'b1111, 44'd20);
        cycle();
        sched(2'd2, 32'h0000_0104, 4'b0101, 44'd21);
        #1;
        chk("block_ready", sched_ready, 1'b0);
        chk("block_req_valid", icache_req_valid, 1'b0);
        cycle();
        rsp(2'd2, 32'h1111_2222);
        #1;
        chk("block_same_cycle", sched_ready, 1'b0);
        cycle();
        icache_rsp_valid = 1'b0;
        #1;
        chk("block_next_cycle", sched_ready, 1'b1);
        cycle();
        sched_valid = 1'b0;
        rsp(2'd2, 32'h3333_4444);
        cycle();
        icache_rsp_valid = 1'b0;
        cycle();

        // Out-of-order responses
        sched(2'd0, 32'h0000_1000, 4'b0001, 44'd100); cycle();
        sched(2'd1, 32'h0000_2004, 4'b0010, 44'd101); cycle();
        sched(2'd2, 32'h0000_3008, 4'b0100, 44'd102); cycle();
        sched_valid = 1'b0;
        rsp(2'd2, 32'hA2); cycle();
        chk("ooo_first", fetch_wid, 2'd2);
        chk("ooo_first_pc", fetch_pc, 32'h0000_3008);
        rsp(2'd0, 32'hA0); cycle();
        chk("ooo_second", fetch_wid, 2'd0);
        chk("ooo_second_uuid", fetch_uuid, 44'd100);
        rsp(2'd1, 32'hA1); cycle();
        chk("ooo_third", fetch_wid, 2'd1);
        chk("ooo_third_pc", fetch_pc, 32'h0000_2004);
        icache_rsp_valid = 1'b0;
        cycle();

        // Backpressure: third response is held off until decode drains
        sched(2'd0, 32'h0000_4000, 4'b1000, 44'd200); cycle();
        sched(2'd1, 32'h0000_4004, 4'b1001, 44'd201); cycle();
        sched(2'd2, 32'h0000_4008, 4'b1010, 44'd202); cycle();
        sched_valid = 1'b0;
        fetch_ready = 1'b0;
        rsp(2'd0, 32'hB0); cycle();
        rsp(2'd1, 32'hB1); cycle();
        rsp(2'd2, 32'hB2);
        #1;
        chk("bp_full_ready", icache_rsp_ready, 1'b0);
        cycle();
        cycle();
        chk("bp_still_pending", pending_warps, 4'b0100);
        fetch_ready = 1'b1;
        cycle();
        cycle();
        icache_rsp_valid = 1'b0;
        chk("bp_last_wid", fetch_wid, 2'd2);
        chk("bp_last_instr", fetch_instr, 32'hB2);
        chk("bp_pend_clear", pending_warps, 4'b0000);
        cycle();
        cycle();

        // Tag error on a non-pending warp, sticky until reset
        rsp(2'd3, 32'hBAD0_0000); cycle();
        icache_rsp_valid = 1'b0;
        chk("terr_set", tag_error, 1'b1);
        chk("terr_dropped", fetch_valid, 1'b0);
        cycle(); cycle(); cycle();
        chk("terr_sticky", tag_error, 1'b1);

        // Stall counter
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("stall_rst_terr", tag_error, 1'b0);
        sched(2'd3, 32'h0000_5000, 4'b1111, 44'd300);
        icache_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        sched_valid = 1'b0;
        icache_req_ready = 1'b1;
        chk("stall_count7", perf_icache_stalls, 32'd7);
        cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("stall_reset", perf_icache_stalls, 32'd0);

        // Reset mid-operation: late response becomes a tag error
        sched(2'd1, 32'h0000_6000, 4'b0001, 44'd400); cycle();
        sched_valid = 1'b0;
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("midrst_pending", pending_warps, 4'b0000);
        rsp(2'd1, 32'hC1); cycle();
        icache_rsp_valid = 1'b0;
        chk("midrst_terr", tag_error, 1'b1);
        chk("midrst_no_out", fetch_valid, 1'b0);
        reset = 1'b1; cycle(); reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int plist [$];
            sched_valid      = ($urandom_range(0, 9) < 6);
            sched_wid        = 2'($urandom_range(0, 3));
            sched_pc         = {30'($urandom), 2'b00};
            sched_tmask      = 4'($urandom);
            sched_uuid       = {12'($urandom), 32'($urandom)};
            icache_req_ready = ($urandom_range(0, 9) < 7);
            fetch_ready      = ($urandom_range(0, 9) < 7);
            icache_rsp_valid = ($urandom_range(0, 9) < 5);
            icache_rsp_data  = $urandom;
            for (int i = 0; i < 4; i++) if (m_pend[i]) plist.push_back(i);
            if (plist.size() != 0 && $urandom_range(0, 9) < 9)
                icache_rsp_tag = 2'(plist[$urandom_range(0, plist.size() - 1)]);
            else
                icache_rsp_tag = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        sched_valid = 1'b0;
        icache_rsp_valid = 1'b0;
        fetch_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly downstream of the warp scheduler. Accepts one scheduled warp per cycle (wid, tmask, PC, uuid) and issues a word-aligned I-cache read tagged by warp id. Keeps a per-warp metadata table, re-joins each cache response with its metadata, and hands the fetched instruction to decode through a 2-entry elastic output buffer. Enforces at most one outstanding fetch per warp and flags protocol violations.

## Interface
- NUM_WARPS, 4: warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- NUM_THREADS, 4: threads per warp (tmask width).
- XLEN, 32: PC width.
- UUID_WIDTH, 44: instruction uuid width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- sched_valid  in  1  scheduled warp valid.
- sched_ready  out  1  stage accepts scheduled warp.
- sched_wid  in  NW_WIDTH  warp id.
- sched_tmask  in  NUM_THREADS  thread mask.
- sched_pc  in  XLEN  fetch PC (bits [1:0] must be 0).
- sched_uuid  in  UUID_WIDTH  instruction uuid.
- icache_req_valid  out  1  cache read request.
- icache_req_ready  in  1  cache accepts request.
- icache_req_addr  out  XLEN-2  word address = sched_pc[XLEN-1:2].
- icache_req_tag  out  NW_WIDTH  = sched_wid.
- icache_rsp_valid  in  1  cache response valid.
- icache_rsp_ready  out  1  stage accepts response.
- icache_rsp_data  in  32  instruction word.
- icache_rsp_tag  in  NW_WIDTH  warp id of response.
- fetch_valid  out  1  instruction to decode valid.
- fetch_ready  in  1  decode accepts.
- fetch_wid / fetch_tmask / fetch_pc / fetch_uuid / fetch_instr  out  NW_WIDTH / NUM_THREADS / XLEN / UUID_WIDTH / 32  fetched instruction bundle.
- pending_warps  out  NUM_WARPS  per-warp outstanding-fetch bits.
- tag_error  out  1  sticky: response arrived for non-pending warp.
- perf_icache_stalls  out  32  cycles with icache_req_valid && !icache_req_ready.

## Operation
- State: pending[NUM_WARPS]; table[NUM_WARPS] of {tmask, pc, uuid}; 2-entry output FIFO; tag_error; stall counter.
- Request path (combinational): icache_req_valid = sched_valid && !pending[sched_wid]; sched_ready = icache_req_ready && !pending[sched_wid]; addr/tag driven from sched_* regardless of valid.
- Request fire (sched_valid && sched_ready): table[sched_wid] <= {tmask, pc, uuid}; pending[sched_wid] <= 1.
- icache_rsp_ready = output FIFO not full (count < 2); independent of pending.
- Response fire: if pending[tag], push {tag, table[tag], rsp_data} into FIFO and clear pending[tag]; else drop the response, set tag_error (sticky until reset), FIFO unchanged.
- Same cycle, different wids, request fire and response fire: both take effect.
- Same wid: request gating uses registered pending, so a request for wid W is blocked in the cycle W's response fires; it may fire the next cycle. No bypass.
- Output FIFO: fetch_* = head entry; fetch_valid = count != 0; pop on fetch_valid && fetch_ready; push and pop may occur in the same cycle at any occupancy, including full (rsp_ready is 0 when full, so no push then).
- perf_icache_stalls increments by 1 per stall cycle; wraps at 2^32.
- No reordering: responses in any order across warps; output order = response order.

## Timing
- Schedule-to-request: 0 cycles (combinational pass-through).
- Response fire to fetch_valid: 1 cycle (FIFO registered); back-to-back responses sustain 1 instruction/cycle when fetch_ready is held high.
- Reset: pending = 0, FIFO empty, fetch_valid = 0, tag_error = 0, perf_icache_stalls = 0, table contents don't-care; fetch_* data = 0. sched_ready/icache_req_valid then follow the combinational rules (sched_ready = icache_req_ready).
- Reset mid-operation: all outstanding fetches discarded; late responses after reset set tag_error.

## Test plan
- Single fetch: wid 1, pc 0x80000010, tmask 4'b0011, uuid 5; req_ready=1 -> req_addr 0x20000004, tag 1, pending_warps 4'b0010; rsp data 0xDEADBEEF tag 1 -> next cycle fetch_valid with wid 1, pc 0x80000010, tmask 0011, uuid 5, instr 0xDEADBEEF; pending_warps 0.
- Per-warp blocking: wid 2 pending, schedule wid 2 again -> sched_ready=0, icache_req_valid=0; response for wid 2 fires cycle N -> still blocked at N, accepted at N+1.
- Out-of-order: fetch wids 0,1,2; responses tags 2,0,1 -> outputs in order 2,0,1 with correct pc/uuid each.
- Backpressure: fetch_ready=0, three responses offered -> two accepted, icache_rsp_ready=0 on third until fetch_ready=1; no loss or duplication.
- Tag error: response tag 3 with no pending -> dropped, no fetch_valid, tag_error=1 and stays 1 until reset.
- Stall counter: icache_req_ready=0 for 7 cycles with sched_valid=1, wid not pending -> perf_icache_stalls = 7; reset -> 0.
